// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small write FIFO.
//   clk_uart    : single clock, rising edge
//   rst         : synchronous reset, active low
//   baud_div    : bit period = baud_div+1 clocks (latched per frame)
//   data_bits   : 0..3 -> 5..8 data bits (capped at DATA_W)
//   parity_mode : 0 none, 1 even, 2 odd, 3 mark
//   stop2       : 1 -> two stop bits
//   break_en    : hold the line low while idle
//   tx_data/tx_valid/tx_ready : FIFO write handshake
//   tx          : serial line, idle high
//   tx_busy     : frame in progress
//   tx_done     : one-cycle pulse at the end of each frame
//   fifo_level  : FIFO occupancy
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                            clk_uart,
  input  logic                            rst,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [1:0]                      data_bits,
  input  logic [1:0]                      parity_mode,
  input  logic                            stop2,
  input  logic                            break_en,
  input  logic [DATA_W-1:0]               tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q;
  logic              rdy_en_q;
  logic              push, launch, empty, full;

  state_t            state_q, state_n;
  logic [DIV_W-1:0]  cnt_q, cnt_n, lat_div_q, lat_div_n;
  logic [DIV_W-1:0]  hold_cnt_q, hold_cnt_n;
  logic              hold_act_q, hold_act_n;
  logic [3:0]        idx_q, idx_n, lat_n_q, lat_n_n, req_bits;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic              par_q, par_n, par_bit;
  logic [1:0]        lat_par_q, lat_par_n;
  logic              lat_stop2_q, lat_stop2_n, stop_q, stop_n;
  logic              tx_q, tx_n, done_q, done_n, tick;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LW'(FIFO_DEPTH));
  // rdy_en_q delays ready to the first edge after reset release
  assign tx_ready   = !full && rst && rdy_en_q;
  assign push       = tx_valid && tx_ready;
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign tx_busy    = (state_q != IDLE);
  assign tick       = (cnt_q == '0);
  assign req_bits   = 4'(data_bits) + 4'd5;
  assign par_bit    = (lat_par_q == 2'd1) ? par_q :
                      (lat_par_q == 2'd2) ? ~par_q : 1'b1;

  always_ff @(posedge clk_uart) begin
    if (push) mem[wptr_q] <= tx_data;
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    idx_n       = idx_q;
    shreg_n     = shreg_q;
    par_n       = par_q;
    tx_n        = tx_q;
    done_n      = 1'b0;
    stop_n      = stop_q;
    hold_act_n  = hold_act_q;
    hold_cnt_n  = hold_cnt_q;
    lat_div_n   = lat_div_q;
    lat_n_n     = lat_n_q;
    lat_par_n   = lat_par_q;
    lat_stop2_n = lat_stop2_q;
    launch      = 1'b0;
    case (state_q)
      IDLE: begin
        if (break_en) begin
          tx_n       = 1'b0;
          hold_act_n = 1'b1;
          hold_cnt_n = baud_div;
        end else begin
          tx_n = 1'b1;
          // after a break the line must idle for one full bit period
          if (hold_act_q) begin
            if (hold_cnt_q == '0) hold_act_n = 1'b0;
            else                  hold_cnt_n = hold_cnt_q - DIV_W'(1);
          end else if (!empty) begin
            launch = 1'b1;
          end
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          cnt_n   = lat_div_q;
          tx_n    = shreg_q[0];
          par_n   = par_q ^ shreg_q[0];
          shreg_n = shreg_q >> 1;
          idx_n   = '0;
        end else cnt_n = cnt_q - DIV_W'(1);
      end
      DATA: begin
        if (tick) begin
          cnt_n = lat_div_q;
          if (idx_q == lat_n_q - 4'd1) begin
            if (lat_par_q != 2'd0) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
              stop_n  = 1'b0;
            end
          end else begin
            idx_n   = idx_q + 4'd1;
            tx_n    = shreg_q[0];
            par_n   = par_q ^ shreg_q[0];
            shreg_n = shreg_q >> 1;
          end
        end else cnt_n = cnt_q - DIV_W'(1);
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          cnt_n   = lat_div_q;
          tx_n    = 1'b1;
          stop_n  = 1'b0;
        end else cnt_n = cnt_q - DIV_W'(1);
      end
      STOP: begin
        if (tick) begin
          if (lat_stop2_q && !stop_q) begin
            stop_n = 1'b1;
            cnt_n  = lat_div_q;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
            tx_n    = 1'b1;
            if (!empty && !break_en) launch = 1'b1;
          end
        end else cnt_n = cnt_q - DIV_W'(1);
      end
      default: state_n = IDLE;
    endcase
    // frame launch shared by IDLE and back-to-back STOP exits
    if (launch) begin
      state_n     = START;
      tx_n        = 1'b0;
      cnt_n       = baud_div;
      lat_div_n   = baud_div;
      lat_n_n     = (req_bits > 4'(DATA_W)) ? 4'(DATA_W) : req_bits;
      lat_par_n   = parity_mode;
      lat_stop2_n = stop2;
      shreg_n     = mem[rptr_q];
      par_n       = 1'b0;
      idx_n       = '0;
      stop_n      = 1'b0;
    end
  end

  always_ff @(posedge clk_uart) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      rdy_en_q    <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      hold_act_q  <= 1'b0;
      hold_cnt_q  <= '0;
      lat_div_q   <= '0;
      lat_n_q     <= '0;
      lat_par_q   <= '0;
      lat_stop2_q <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      if (push)   wptr_q <= wptr_q + AW'(1);
      if (launch) rptr_q <= rptr_q + AW'(1);
      if (push && !launch)      level_q <= level_q + LW'(1);
      else if (!push && launch) level_q <= level_q - LW'(1);
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      idx_q       <= idx_n;
      shreg_q     <= shreg_n;
      par_q       <= par_n;
      tx_q        <= tx_n;
      done_q      <= done_n;
      stop_q      <= stop_n;
      hold_act_q  <= hold_act_n;
      hold_cnt_q  <= hold_cnt_n;
      lat_div_q   <= lat_div_n;
      lat_n_q     <= lat_n_n;
      lat_par_q   <= lat_par_n;
      lat_stop2_q <= lat_stop2_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo. Expected line
// waveforms are built from the frame format (start, data LSB first,
// parity, stops) and compared cycle by cycle.
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int DIVW = 16;

  logic            clk_uart = 1'b0;
  logic            rst = 1'b0;
  logic [DIVW-1:0] baud_div = '0;
  logic [1:0]      data_bits = '0;
  logic [1:0]      parity_mode = '0;
  logic            stop2 = 1'b0;
  logic            break_en = 1'b0;
  logic [DW-1:0]   tx_data = '0;
  logic            tx_valid = 1'b0;
  logic            tx_ready, tx, tx_busy, tx_done;
  logic [3:0]      fifo_level;

  int checks = 0;
  int failures = 0;
  logic [7:0] expq[$];

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .clk_uart(clk_uart), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
    .parity_mode(parity_mode), .stop2(stop2), .break_en(break_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
    .tx_busy(tx_busy), .tx_done(tx_done), .fifo_level(fifo_level)
  );

  always #5 clk_uart = ~clk_uart;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk_uart);
    #1;
  endtask

  task automatic set_cfg(input int div, input int db, input int pm, input int s2);
    baud_div    = DIVW'(div);
    data_bits   = 2'(db);
    parity_mode = 2'(pm);
    stop2       = 1'(s2);
  endtask

  // Called at the sample point just after the edge that started the frame;
  // returns at the sample point just after the edge that ends it.
  task automatic check_frame(input string tag, input logic [7:0] w, input int div,
                             input int db, input int pm, input int s2);
    bit bq[$];
    bit p;
    int nb, per, total, errs, berrs, derrs;
    nb = db + 5;
    p = 1'b0;
    bq.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bq.push_back(w[i]);
      p = p ^ w[i];
    end
    if (pm == 1) bq.push_back(p);
    else if (pm == 2) bq.push_back(~p);
    else if (pm == 3) bq.push_back(1'b1);
    bq.push_back(1'b1);
    if (s2 != 0) bq.push_back(1'b1);
    per = div + 1;
    total = bq.size() * per;
    errs = 0; berrs = 0; derrs = 0;
    for (int c = 0; c < total; c++) begin
      if (c > 0) tick1();
      if (tx !== bq[c / per]) errs++;
      if (tx_busy !== 1'b1) berrs++;
      if (c > 0 && tx_done !== 1'b0) derrs++;
    end
    tick1();
    chk({tag, " line"}, errs, 0);
    chk({tag, " busy"}, berrs, 0);
    chk({tag, " early_done"}, derrs, 0);
    chk({tag, " done"}, tx_done, 1'b1);
  endtask

  task automatic single(input string tag, input logic [7:0] w, input int div,
                        input int db, input int pm, input int s2);
    set_cfg(div, db, pm, s2);
    tx_valid = 1'b1;
    tx_data  = w;
    tick1();
    tx_valid = 1'b0;
    chk({tag, " accept_tx"}, tx, 1'b1);
    chk({tag, " accept_lvl"}, fifo_level, 4'd1);
    tick1();
    check_frame(tag, w, div, db, pm, s2);
    chk({tag, " idle_tx"}, tx, 1'b1);
    chk({tag, " idle_busy"}, tx_busy, 1'b0);
    chk({tag, " idle_lvl"}, fifo_level, 4'd0);
  endtask

  task automatic push_pair(input logic [7:0] w1, input logic [7:0] w2);
    tx_valid = 1'b1;
    tx_data  = w1;
    tick1();
    tx_data  = w2;
    tick1();
    tx_valid = 1'b0;
    chk("pair_lvl", fifo_level, 4'd1);
  endtask

  initial begin
    logic [7:0] w1, w2;
    int errs, hi;

    // reset state and ready release
    repeat (3) tick1();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_lvl", fifo_level, 4'd0);
    chk("rst_ready", tx_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", tx_ready, 1'b0);
    tick1();
    chk("ready_after_edge", tx_ready, 1'b1);

    // directed frames
    single("a5", 8'hA5, 3, 3, 0, 0);
    single("even17", 8'h17, 1, 0, 1, 0);
    single("odd00", 8'h00, 2, 3, 2, 0);
    single("mark", 8'($urandom), 1, 2, 3, 1);

    // random configurations and words
    for (int k = 0; k < 16; k++) begin
      single("rnd", 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1));
    end

    // fill the FIFO while a frame is in flight, then drain back-to-back
    set_cfg(1, 3, 0, 0);
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    fork
      begin
        int acc, guard;
        logic r;
        acc = 0; guard = 0;
        while (acc < 9 && guard < 200) begin
          r = tx_ready;
          tick1();
          guard++;
          if (r) begin
            expq.push_back(tx_data);
            acc++;
            tx_data = 8'($urandom);
          end
        end
        chk("fill_accepted", acc, 9);
        chk("fill_lvl", fifo_level, 4'd8);
        chk("fill_ready", tx_ready, 1'b0);
        repeat (3) tick1();
        chk("full_hold_lvl", fifo_level, 4'd8);
        chk("full_hold_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
      end
      begin
        tick1();
        tick1();
        for (int k = 0; k < 9; k++) begin
          if (k > 0) begin
            chk("drain_lvl", fifo_level, 4'(8 - k));
            chk("b2b_no_gap", tx, 1'b0);
          end
          check_frame("drain", expq.pop_front(), 1, 3, 0, 0);
        end
        chk("drain_end_tx", tx, 1'b1);
        chk("drain_end_busy", tx_busy, 1'b0);
        chk("drain_end_lvl", fifo_level, 4'd0);
      end
    join

    // two stop bits, one-cycle bits, back-to-back
    w1 = 8'($urandom); w2 = 8'($urandom);
    set_cfg(0, 3, 0, 1);
    push_pair(w1, w2);
    check_frame("stop2_a", w1, 0, 3, 0, 1);
    check_frame("stop2_b", w2, 0, 3, 0, 1);
    chk("stop2_idle", tx_busy, 1'b0);

    // configuration change mid-frame applies to the next frame only
    w1 = 8'($urandom); w2 = 8'($urandom);
    set_cfg(2, 3, 0, 0);
    push_pair(w1, w2);
    fork
      begin
        repeat (5) tick1();
        set_cfg(4, 1, 1, 0);
      end
      begin
        check_frame("cfg_old", w1, 2, 3, 0, 0);
        check_frame("cfg_new", w2, 4, 1, 1, 0);
      end
    join
    chk("cfg_idle", tx_busy, 1'b0);

    // break asserted mid-frame
    w1 = 8'($urandom); w2 = 8'($urandom);
    set_cfg(3, 3, 0, 0);
    push_pair(w1, w2);
    fork
      begin
        repeat (6) tick1();
        break_en = 1'b1;
      end
      check_frame("brk_frame", w1, 3, 3, 0, 0);
    join
    chk("brk_busy", tx_busy, 1'b0);
    chk("brk_lvl", fifo_level, 4'd1);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      tick1();
      if (tx !== 1'b0 || fifo_level !== 4'd1 || tx_busy !== 1'b0) errs++;
    end
    chk("brk_hold", errs, 0);
    break_en = 1'b0;
    tick1();
    chk("brk_release_tx", tx, 1'b1);
    hi = 1;
    while (tx === 1'b1 && hi < 100) begin
      tick1();
      if (tx === 1'b1) hi++;
    end
    chk("brk_gap_bound", hi < 100, 1'b1);
    chk("brk_gap_min", hi >= 4, 1'b1);
    check_frame("brk_next", w2, 3, 3, 0, 0);
    chk("brk_end_lvl", fifo_level, 4'd0);

    // reset mid-frame with words queued
    set_cfg(2, 3, 0, 0);
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data = 8'($urandom);
      tick1();
    end
    tx_valid = 1'b0;
    repeat (4) tick1();
    chk("pre_rst_lvl", fifo_level, 4'd3);
    chk("pre_rst_busy", tx_busy, 1'b1);
    rst = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'($urandom);
    tick1();
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_lvl", fifo_level, 4'd0);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_ready", tx_ready, 1'b0);
    tick1();
    chk("rst_write_ignored", fifo_level, 4'd0);
    tx_valid = 1'b0;
    rst = 1'b1;
    tick1();
    chk("post_rst_ready", tx_ready, 1'b1);
    errs = 0;
    for (int c = 0; c < 60; c++) begin
      tick1();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 4'd0) errs++;
    end
    chk("post_rst_quiet", errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
